// File: rtl/smi_mem_lib_write_split_pkg.sv
// rtl/smi_mem_lib_write_split_pkg.sv - shared constants and state enum for the SMI write splitter
package smi_mem_lib_write_split_pkg;

  localparam logic [7:0] SMI_EOFC_MID  = 8'd0;
  localparam logic [7:0] SMI_EOFC_FULL = 8'd8;

  localparam logic [7:0] SMI_MEM_WRITE_OPT_NONE     = 8'h00;
  localparam logic [7:0] SMI_MEM_WRITE_OPT_POSTED   = 8'h01;
  localparam logic [7:0] SMI_MEM_WRITE_OPT_NO_SNOOP = 8'h02;
  localparam logic [7:0] SMI_MEM_WRITE_OPT_RELAXED  = 8'h04;

  localparam logic [7:0] SMI_MEM_WRITE_REQ_ID = 8'h05;
  localparam logic [7:0] SMI_MEM_WRITE_RSP_ID = 8'h85;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_STREAM,
    ST_COMPLETE
  } wsplit_state_e;

  // Final-word byte count from the low bits of the burst length (0 means a full word).
  function automatic logic [7:0] last_eofc(input logic [2:0] len_lo);
    return (len_lo == 3'd0) ? SMI_EOFC_FULL : {5'd0, len_lo};
  endfunction

endpackage

// File: rtl/smi_mem_lib_burst_calc.sv
// rtl/smi_mem_lib_burst_calc.sv - next burst length and word count from address offset and bytes remaining
module smi_mem_lib_burst_calc #(
  parameter int MaxBurstBytes = 256
) (
  input  logic [$clog2(MaxBurstBytes)-1:0] addr_off,
  input  logic [31:0]                      remaining,
  output logic [15:0]                      burst_len,
  output logic [12:0]                      word_count
);

  logic [12:0] room;

  // MaxBurstBytes divides 4 KiB, so staying inside one burst window also avoids 4 KiB crossings.
  always_comb begin
    room       = 13'(MaxBurstBytes) - 13'(addr_off);
    burst_len  = (remaining < 32'(room)) ? remaining[15:0] : {3'b000, room};
    word_count = 13'(burst_len[15:3]) + 13'(burst_len[2:0] != 3'b000);
  end

endmodule

// File: rtl/smi_mem_lib_write_split.sv
// rtl/smi_mem_lib_write_split.sv - splits one write transfer into aligned SMI bursts
// Optional statBurstCount output under SMI_MEM_WRITE_SPLIT_STATS_EN.
module smi_mem_lib_write_split
  import smi_mem_lib_write_split_pkg::*;
#(
  parameter int MaxBurstBytes  = 256,
  parameter int MaxOutstanding = 4
) (
  input  logic        clk,
  input  logic        srst,
`ifdef SMI_MEM_WRITE_SPLIT_STATS_EN
  output logic [15:0] statBurstCount,
`endif
  input  logic        xferValid,
  output logic        xferStop,
  input  logic [63:0] xferAddr,
  input  logic [31:0] xferLen,
  input  logic [7:0]  xferOpts,
  input  logic        dataInValid,
  output logic        dataInStop,
  input  logic [63:0] dataIn,
  output logic        burstParamsValid,
  input  logic        burstParamsStop,
  output logic [63:0] burstAddr,
  output logic [15:0] burstLen,
  output logic [7:0]  burstOpts,
  output logic        burstWriteValid,
  input  logic        burstWriteStop,
  output logic [7:0]  burstWriteEofc,
  output logic [63:0] burstWriteData,
  input  logic        burstDoneValid,
  input  logic        burstDoneStatusOk,
  output logic        burstDoneStop,
  output logic        xferDoneValid,
  output logic        xferDoneStatusOk,
  input  logic        xferDoneStop
);

  localparam int OffW = $clog2(MaxBurstBytes);

  wsplit_state_e state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] rem_q, rem_d;
  logic [7:0]  opts_q, opts_d;
  logic        status_q, status_d;
  logic [3:0]  outst_q, outst_d;
  logic [15:0] blen_q, blen_d;
  logic [12:0] words_q, words_d;
  logic [15:0] calc_len;
  logic [12:0] calc_words;
  logic        param_fire, done_fire;

  smi_mem_lib_burst_calc #(.MaxBurstBytes(MaxBurstBytes)) u_burst_calc (
    .addr_off   (addr_q[OffW-1:0]),
    .remaining  (rem_q),
    .burst_len  (calc_len),
    .word_count (calc_words)
  );

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    rem_d            = rem_q;
    opts_d           = opts_q;
    status_d         = status_q;
    blen_d           = blen_q;
    words_d          = words_q;
    outst_d          = outst_q;
    xferStop         = 1'b1;
    dataInStop       = 1'b1;
    burstParamsValid = 1'b0;
    burstAddr        = '0;
    burstLen         = '0;
    burstOpts        = '0;
    burstWriteValid  = 1'b0;
    burstWriteEofc   = SMI_EOFC_MID;
    burstWriteData   = '0;
    xferDoneValid    = 1'b0;
    param_fire       = 1'b0;
    done_fire        = burstDoneValid && (outst_q != 4'd0);

    case (state_q)
      ST_IDLE: begin
        xferStop = 1'b0;
        if (xferValid) begin
          addr_d   = xferAddr;
          rem_d    = xferLen;
          opts_d   = xferOpts;
          status_d = 1'b1;
          state_d  = (xferLen == 32'd0) ? ST_COMPLETE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (outst_q != 4'(MaxOutstanding)) begin
          burstParamsValid = 1'b1;
          burstAddr        = addr_q;
          burstLen         = calc_len;
          burstOpts        = opts_q;
          if (!burstParamsStop) begin
            param_fire = 1'b1;
            blen_d     = calc_len;
            words_d    = calc_words;
            state_d    = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        burstWriteValid = dataInValid;
        dataInStop      = burstWriteStop;
        burstWriteData  = dataIn;
        if (words_q == 13'd1) burstWriteEofc = last_eofc(blen_q[2:0]);
        if (dataInValid && !burstWriteStop) begin
          words_d = words_q - 13'd1;
          if (words_q == 13'd1) begin
            addr_d  = addr_q + 64'(blen_q);
            rem_d   = rem_q - 32'(blen_q);
            state_d = (rem_q == 32'(blen_q)) ? ST_COMPLETE : ST_ISSUE;
          end
        end
      end
      ST_COMPLETE: begin
        if (outst_q == 4'd0) begin
          xferDoneValid = 1'b1;
          if (!xferDoneStop) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done_fire) status_d = status_d & burstDoneStatusOk;
    if (param_fire && !done_fire) outst_d = outst_q + 4'd1;
    else if (!param_fire && done_fire) outst_d = outst_q - 4'd1;
  end

  assign burstDoneStop    = 1'b0;
  assign xferDoneStatusOk = status_q;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      opts_q   <= '0;
      status_q <= 1'b1;
      outst_q  <= '0;
      blen_q   <= '0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      opts_q   <= opts_d;
      status_q <= status_d;
      outst_q  <= outst_d;
      blen_q   <= blen_d;
      words_q  <= words_d;
    end
  end

`ifdef SMI_MEM_WRITE_SPLIT_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (state_q == ST_IDLE && xferValid) stat_d = '0;
    else if (param_fire && stat_q != 16'hFFFF) stat_d = stat_q + 16'd1;
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) stat_q <= '0;
    else      stat_q <= stat_d;
  end

  assign statBurstCount = stat_q;
`endif

endmodule

// File: tb/tb_smi_mem_lib_write_split.sv
// tb/tb_smi_mem_lib_write_split.sv - randomized self-checking bench for the SMI write splitter
module tb_smi_mem_lib_write_split;

  localparam int MBB = 256;
  localparam int MOS = 4;

  logic        clk = 1'b0;
  logic        srst;
  logic        xferValid, xferStop;
  logic [63:0] xferAddr;
  logic [31:0] xferLen;
  logic [7:0]  xferOpts;
  logic        dataInValid, dataInStop;
  logic [63:0] dataIn;
  logic        burstParamsValid, burstParamsStop;
  logic [63:0] burstAddr;
  logic [15:0] burstLen;
  logic [7:0]  burstOpts;
  logic        burstWriteValid, burstWriteStop;
  logic [7:0]  burstWriteEofc;
  logic [63:0] burstWriteData;
  logic        burstDoneValid, burstDoneStatusOk, burstDoneStop;
  logic        xferDoneValid, xferDoneStatusOk, xferDoneStop;

  always #5 clk = ~clk;

  smi_mem_lib_write_split #(.MaxBurstBytes(MBB), .MaxOutstanding(MOS)) dut (
    .clk(clk), .srst(srst),
    .xferValid(xferValid), .xferStop(xferStop), .xferAddr(xferAddr), .xferLen(xferLen), .xferOpts(xferOpts),
    .dataInValid(dataInValid), .dataInStop(dataInStop), .dataIn(dataIn),
    .burstParamsValid(burstParamsValid), .burstParamsStop(burstParamsStop),
    .burstAddr(burstAddr), .burstLen(burstLen), .burstOpts(burstOpts),
    .burstWriteValid(burstWriteValid), .burstWriteStop(burstWriteStop),
    .burstWriteEofc(burstWriteEofc), .burstWriteData(burstWriteData),
    .burstDoneValid(burstDoneValid), .burstDoneStatusOk(burstDoneStatusOk), .burstDoneStop(burstDoneStop),
    .xferDoneValid(xferDoneValid), .xferDoneStatusOk(xferDoneStatusOk), .xferDoneStop(xferDoneStop)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [63:0] mb_addr[$];
  int          mb_len[$];

  // Reference burst list: cut at every MaxBurstBytes window edge.
  task automatic build_model(input logic [63:0] a, input int unsigned len);
    logic [63:0] aa;
    int unsigned rem, room, l;
    aa = a;
    rem = len;
    mb_addr.delete();
    mb_len.delete();
    while (rem != 0) begin
      room = MBB - int'(aa % MBB);
      l = (rem < room) ? rem : room;
      mb_addr.push_back(aa);
      mb_len.push_back(int'(l));
      aa = aa + 64'(l);
      rem = rem - l;
    end
  endtask

  task automatic run_xfer(input logic [63:0] a, input int unsigned len, input logic [7:0] opts,
                          input int status_mode, input int abort_word, input bit hold_mode,
                          output int nb);
    int pidx, didx, widx, pending, cyc, total, stall, rel_cyc, ndone, nw;
    bit exp_ok, fin, released, force_done;
    bit p_fire, w_fire, d_fire, x_fire, in_fire;
    pidx = 0; didx = 0; widx = 0; pending = 0; cyc = 0; total = 0;
    stall = 0; rel_cyc = 0; ndone = 0;
    exp_ok = 1'b1; fin = 1'b0; released = 1'b0;
    build_model(a, len);
    nb = 0;
    @(negedge clk);
    check("xfer_stop_idle", xferStop, 1'b0);
    xferValid = 1'b1; xferAddr = a; xferLen = len; xferOpts = opts;
    @(posedge clk); #1;
    xferValid = 1'b0; xferAddr = {$urandom, $urandom}; xferLen = $urandom; xferOpts = 8'($urandom);
    @(negedge clk);
    check("first_params_lat", burstParamsValid, len != 0);
    check("len0_done_lat", xferDoneValid, len == 0);
    while (!fin) begin
      if (cyc > 8000) begin
        check("timeout", 64'(cyc), 64'(8000));
        break;
      end
      p_fire  = burstParamsValid && !burstParamsStop;
      w_fire  = burstWriteValid && !burstWriteStop;
      d_fire  = burstDoneValid && !burstDoneStop;
      x_fire  = xferDoneValid && !xferDoneStop;
      in_fire = dataInValid && !dataInStop;
      if (burstDoneValid) check("done_stop", burstDoneStop, 1'b0);
      if (p_fire) begin
        check("outstanding_le_max", pending < MOS, 1'b1);
        if (pidx < mb_len.size()) begin
          check("burst_addr", burstAddr, mb_addr[pidx]);
          check("burst_len", 64'(burstLen), 64'(mb_len[pidx]));
          check("burst_opts", burstOpts, opts);
        end else check("extra_burst", 64'(pidx + 1), 64'(mb_len.size()));
        if (hold_mode && pidx == MOS) check("release_lat_le2", released && (cyc - rel_cyc <= 2), 1'b1);
        pidx++;
        pending++;
      end
      if (w_fire) begin
        check("wdata", burstWriteData, dataIn);
        check("data_stop_pass", in_fire, 1'b1);
        check("word_after_params", didx < pidx, 1'b1);
        if (didx < mb_len.size()) begin
          nw = (mb_len[didx] + 7) / 8;
          check("eofc", burstWriteEofc, (widx == nw - 1) ? 64'(((mb_len[didx] - 1) % 8) + 1) : 64'd0);
          widx++;
          if (widx == nw) begin
            widx = 0;
            didx++;
          end
        end else check("extra_word", 64'(didx + 1), 64'(mb_len.size()));
        total++;
        if (abort_word != 0 && total == abort_word) begin
          srst = 1'b1;
          #1;
          check("rst_params_valid", burstParamsValid, 1'b0);
          check("rst_write_valid", burstWriteValid, 1'b0);
          check("rst_xfer_done", xferDoneValid, 1'b0);
          check("rst_xfer_stop", xferStop, 1'b0);
          check("rst_data_stop", dataInStop, 1'b1);
          xferValid = 1'b0; dataInValid = 1'b0; burstDoneValid = 1'b0;
          @(posedge clk); #1;
          srst = 1'b0;
          nb = pidx;
          return;
        end
      end
      if (d_fire) begin
        pending--;
        ndone++;
        exp_ok = exp_ok & burstDoneStatusOk;
      end
      if (x_fire) begin
        check("all_bursts_issued", 64'(pidx), 64'(mb_len.size()));
        check("all_bursts_streamed", 64'(didx), 64'(mb_len.size()));
        check("no_pending_done", 64'(pending), 64'd0);
        check("xfer_status", xferDoneStatusOk, exp_ok);
        fin = 1'b1;
      end
      force_done = 1'b0;
      if (hold_mode && !released && didx == MOS) begin
        stall++;
        if (stall == 10) begin
          check("stall_issued", 64'(pidx), 64'(MOS));
          check("stall_params_low", burstParamsValid, 1'b0);
          released = 1'b1;
          rel_cyc = cyc;
          force_done = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
      burstParamsStop = hold_mode ? 1'b0 : ($urandom_range(0, 3) == 0);
      burstWriteStop  = ($urandom_range(0, 2) == 0);
      xferDoneStop    = 1'($urandom_range(0, 1));
      if (!dataInValid || in_fire) begin
        dataInValid = ($urandom_range(0, 3) != 0);
        dataIn = {$urandom, $urandom};
      end
      if (force_done || (!(hold_mode && !released) && pending > 0 && $urandom_range(0, 1) == 1)) begin
        burstDoneValid = 1'b1;
        if (status_mode == -1) burstDoneStatusOk = ($urandom_range(0, 7) != 0);
        else if (status_mode == -2) burstDoneStatusOk = 1'b1;
        else burstDoneStatusOk = (ndone != status_mode);
      end else burstDoneValid = 1'b0;
      @(negedge clk);
    end
    dataInValid = 1'b0; burstDoneValid = 1'b0;
    burstParamsStop = 1'b0; burstWriteStop = 1'b0; xferDoneStop = 1'b0;
    nb = pidx;
  endtask

  initial begin
    int nb;
    logic [63:0] ra;
    srst = 1'b1;
    xferValid = 1'b0; xferAddr = '0; xferLen = '0; xferOpts = '0;
    dataInValid = 1'b1; dataIn = 64'hDEAD_BEEF_0123_4567;
    burstParamsStop = 1'b0; burstWriteStop = 1'b0;
    burstDoneValid = 1'b0; burstDoneStatusOk = 1'b1; xferDoneStop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_xfer_stop", xferStop, 1'b0);
    check("reset_data_stop", dataInStop, 1'b1);
    check("reset_params_valid", burstParamsValid, 1'b0);
    check("reset_write_valid", burstWriteValid, 1'b0);
    check("reset_done_stop", burstDoneStop, 1'b0);
    check("reset_xfer_done", xferDoneValid, 1'b0);
    check("reset_status_ok", xferDoneStatusOk, 1'b1);
    check("reset_burst_addr", burstAddr, 64'd0);
    check("reset_burst_len", 64'(burstLen), 64'd0);
    check("reset_write_data", burstWriteData, 64'd0);
    check("reset_eofc", burstWriteEofc, 64'd0);
    @(posedge clk); #1;
    srst = 1'b0;
    dataInValid = 1'b0;

    run_xfer(64'h1000, 600, 8'h01, -2, 0, 1'b0, nb);
    check("nbursts_600", 64'(nb), 64'd3);
    run_xfer(64'h10F0, 61, 8'h02, -2, 0, 1'b0, nb);
    check("nbursts_61", 64'(nb), 64'd2);
    run_xfer(64'h2000, 700, 8'h04, 1, 0, 1'b0, nb);
    check("nbursts_bad_status", 64'(nb), 64'd3);
    run_xfer(64'h0, 2048, 8'h00, -2, 0, 1'b1, nb);
    check("nbursts_hold", 64'(nb), 64'd8);
    run_xfer(64'h3000, 0, 8'h00, -2, 0, 1'b0, nb);
    check("nbursts_len0", 64'(nb), 64'd0);
    run_xfer(64'h1000, 600, 8'h01, -2, 3, 1'b0, nb);
    run_xfer(64'h1000, 600, 8'h01, -2, 0, 1'b0, nb);
    check("nbursts_after_reset", 64'(nb), 64'd3);
    run_xfer(64'hFFFF_FFFF_FFFF_FF80, 300, 8'h02, -2, 0, 1'b0, nb);
    check("nbursts_wrap", 64'(nb), 64'd2);
    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom} & ~64'h7;
      run_xfer(ra, $urandom_range(0, 1500), 8'($urandom), -1, 0, 1'b0, nb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
